// File: rtl/reg_writeback.sv
// Register file write-port driver: serialises dual-write retiring entries, extracts LDRB bytes
// and flags writes to r15.
module reg_writeback #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned FULLW      = 32,
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned WORD       = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_we1,
   input  logic [ADDR_WIDTH-1:0] in_wa1,
   input  logic [FULLW-1:0]      in_wd1,
   input  logic                  in_isload,
   input  logic                  in_byte,
   input  logic [1:0]            in_bsel,
   input  logic                  in_we2,
   input  logic [ADDR_WIDTH-1:0] in_wa2,
   input  logic [FULLW-1:0]      in_wd2,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] wa,
   output logic [FULLW-1:0]      wd,
   output logic                  pc_write,
   output logic [31:0]           wr_count
);

   typedef enum logic [0:0] {StIdle, StWr2} state_e;

   state_e                  state_q, state_d;
   logic                    we_d;
   logic [ADDR_WIDTH-1:0]   wa_d, wa2_q, wa2_d;
   logic [FULLW-1:0]        wd_d, wd2_q, wd2_d;
   logic                    pc_write_d;
   logic [31:0]             wr_count_d;
   logic                    accept;
   logic [FULLW-1:0]        d1;
   logic [WIDTH-1:0]        lane;

   assign in_ready = reset && (state_q == StIdle);
   assign accept   = in_valid && in_ready;

   // Byte 0 is the most significant lane of the word.
   always_comb begin
      lane = '0;
      for (int i = 0; i < WORD; i++) begin
         if (in_bsel == i[1:0]) begin
            lane = in_wd1[FULLW-1-i*WIDTH -: WIDTH];
         end
      end
      d1 = (in_isload && in_byte) ? {{(FULLW-WIDTH){1'b0}}, lane} : in_wd1;
   end

   always_comb begin
      state_d = state_q;
      we_d    = 1'b0;
      wa_d    = wa;
      wd_d    = wd;
      wa2_d   = wa2_q;
      wd2_d   = wd2_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (in_we1) begin
                  we_d = 1'b1;
                  wa_d = in_wa1;
                  wd_d = d1;
                  // Same-address secondary write is dropped so the load data wins.
                  if (in_we2 && (in_wa1 != in_wa2)) begin
                     wa2_d   = in_wa2;
                     wd2_d   = in_wd2;
                     state_d = StWr2;
                  end
               end else if (in_we2) begin
                  we_d = 1'b1;
                  wa_d = in_wa2;
                  wd_d = in_wd2;
               end
            end
         end
         StWr2: begin
            we_d    = 1'b1;
            wa_d    = wa2_q;
            wd_d    = wd2_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      pc_write_d = we_d && (&wa_d);
      wr_count_d = we_d ? wr_count + 32'd1 : wr_count;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         we       <= 1'b0;
         wa       <= '0;
         wd       <= '0;
         pc_write <= 1'b0;
         wr_count <= '0;
         wa2_q    <= '0;
         wd2_q    <= '0;
      end else begin
         state_q  <= state_d;
         we       <= we_d;
         wa       <= wa_d;
         wd       <= wd_d;
         pc_write <= pc_write_d;
         wr_count <= wr_count_d;
         wa2_q    <= wa2_d;
         wd2_q    <= wd2_d;
      end
   end

endmodule
